// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data access.
// Optional macro ARB_FAIRNESS_EN bounds consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        owner
);

    // Handshake: a requester raises x_req and holds it (with its address/data) until
    // x_ready pulses for one cycle; on the memory side mem_req stays high until mem_ack.
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GNT_IF  = 3'd1;
    localparam logic [2:0] GNT_DM  = 3'd2;
    localparam logic [2:0] DONE_IF = 3'd3;
    localparam logic [2:0] DONE_DM = 3'd4;

    logic [2:0] state;
    logic       fair_force;
    logic       grant_dm;
    logic       grant_if;

    // An out-of-range MAX_DATA_STREAK shows up as this named block in the hierarchy.
    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_max_data_streak
    end

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak;

    assign fair_force = if_req && (streak == STREAK_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (grant_dm && if_req) begin
                streak <= streak + 4'd1;
            end else if (!if_req || grant_if) begin
                streak <= '0;
            end
        end
    end
`else
    assign fair_force = 1'b0;
`endif

    assign grant_dm = dm_req && !fair_force;
    assign grant_if = if_req && !grant_dm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= GNT_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_if) begin
                        state    <= GNT_IF;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                GNT_IF: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        mem_req  <= 1'b0;
                        state    <= DONE_IF;
                    end
                end
                GNT_DM: begin
                    if (mem_ack) begin
                        // Stores leave the previous load result visible.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        state   <= DONE_DM;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_ready = (state == DONE_IF);
    assign dm_ready = (state == DONE_DM);
    assign busy     = (state != IDLE);

    always_comb begin
        owner = 2'b00;
        if (state == GNT_IF) begin
            owner = 2'b01;
        end else if (state == GNT_DM) begin
            owner = 2'b10;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, random run vs model.
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 2;
    localparam int P_FREE = 0;
    localparam int P_ACC  = 1;
    localparam int P_FIN  = 2;
    localparam int NVEC   = 22;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  owner;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        chk_aw;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        chk_wd;
        logic [31:0] e_mem_wdata;
        logic        e_if_ready;
        logic        e_dm_ready;
        logic [1:0]  e_owner;
        logic        e_busy;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Random-run model state
    int          ph;
    int          cur_who;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_we;
    int          wait_n;
    int          streak_m;
    logic        force_if;
    logic        if_act;
    logic        dm_act;
    logic [31:0] if_a;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic        dm_w;
    logic [31:0] mem_model [16];
    logic [31:0] exp_ifd;
    logic [31:0] exp_dmd;
    int          n_if_done;
    int          n_dm_done;
    logic [31:0] got_who;
    int          k;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        dm_req    = v.dm_req;
        dm_we     = v.dm_we;
        dm_addr   = v.dm_addr;
        dm_wdata  = v.dm_wdata;
        mem_ack   = v.mem_ack;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("vec%0d.mem_req", i), 32'(mem_req), 32'(v.e_mem_req));
        if (v.chk_aw) begin
            chk($sformatf("vec%0d.mem_we", i), 32'(mem_we), 32'(v.e_mem_we));
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, v.e_mem_addr);
        end
        if (v.chk_wd) begin
            chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, v.e_mem_wdata);
        end
        chk($sformatf("vec%0d.if_ready", i), 32'(if_ready), 32'(v.e_if_ready));
        chk($sformatf("vec%0d.dm_ready", i), 32'(dm_ready), 32'(v.e_dm_ready));
        chk($sformatf("vec%0d.owner", i), 32'(owner), 32'(v.e_owner));
        chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(v.e_busy));
        chk($sformatf("vec%0d.if_rdata", i), if_rdata, v.e_if_rdata);
        chk($sformatf("vec%0d.dm_rdata", i), dm_rdata, v.e_dm_rdata);
    endtask

    initial begin
        // Fields: if_req,if_addr,dm_req,dm_we,dm_addr,dm_wdata,ack,rdata | mem_req,chk_aw,we,addr,chk_wd,wdata,if_rdy,dm_rdy,owner,busy,if_rdata,dm_rdata
        vecs[0]  = '{1, 32'h10, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 32'h10, 0, 0, 0, 0, 2'd1, 1, 0, 0};
        vecs[1]  = '{1, 32'h10, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 32'h10, 0, 0, 0, 0, 2'd1, 1, 0, 0};
        vecs[2]  = '{1, 32'h10, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 32'h10, 0, 0, 0, 0, 2'd1, 1, 0, 0};
        vecs[3]  = '{1, 32'h10, 0, 0, 0, 0, 1, 32'h00100093, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 32'h00100093, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h00100093, 0};
        vecs[5]  = '{0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 1, 1, 1, 32'h40, 1, 32'hDEADBEEF, 0, 0, 2'd2, 1, 32'h00100093, 0};
        vecs[6]  = '{0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1, 32'h00100093, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h00100093, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h00100093, 0};
        vecs[9]  = '{1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 0, 0, 0, 0, 2'd1, 1, 32'h00100093, 0};
        vecs[10] = '{1, 32'h20, 0, 0, 0, 0, 1, 32'h11111111, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 32'h11111111, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h11111111, 0};
        vecs[12] = '{0, 0, 1, 0, 32'h44, 32'h12345678, 0, 0, 1, 1, 0, 32'h44, 1, 32'h12345678, 0, 0, 2'd2, 1, 32'h11111111, 0};
        vecs[13] = '{0, 0, 1, 0, 32'h44, 32'h12345678, 1, 32'h22222222, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1, 32'h11111111, 32'h22222222};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 1, 32'h66666666, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h11111111, 32'h22222222};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 32'h77777777, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h11111111, 32'h22222222};
        vecs[16] = '{1, 32'h30, 1, 1, 32'h48, 32'hCAFEF00D, 0, 0, 1, 1, 1, 32'h48, 1, 32'hCAFEF00D, 0, 0, 2'd2, 1, 32'h11111111, 32'h22222222};
        vecs[17] = '{1, 32'h30, 1, 1, 32'h48, 32'hCAFEF00D, 1, 32'h99999999, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1, 32'h11111111, 32'h22222222};
        vecs[18] = '{1, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h11111111, 32'h22222222};
        vecs[19] = '{1, 32'h30, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h30, 0, 0, 0, 0, 2'd1, 1, 32'h11111111, 32'h22222222};
        vecs[20] = '{1, 32'h30, 0, 0, 0, 0, 1, 32'h44444444, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 32'h44444444, 32'h22222222};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h44444444, 32'h22222222};

        // Reset with every input active: reset must dominate.
        reset = 1'b1;
        drive_idle();
        if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hABCDABCD;
        dm_we = 1'b1; dm_addr = 32'h4; dm_wdata = 32'h5; if_addr = 32'h8;
        repeat (3) tick();
        chk("reset.mem_req", 32'(mem_req), 0);
        chk("reset.mem_we", 32'(mem_we), 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.if_ready", 32'(if_ready), 0);
        chk("reset.dm_ready", 32'(dm_ready), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.owner", 32'(owner), 0);
        chk("reset.if_rdata", if_rdata, 0);
        chk("reset.dm_rdata", dm_rdata, 0);
        reset = 1'b0;
        drive_idle();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i]);
            tick();
            check_vec(i, vecs[i]);
        end
        drive_idle();
        tick();

        // Both requests held, zero-wait memory: completion order and 3-cycle cadence.
        for (int j = 0; j < 12; j++) begin
`ifdef ARB_FAIRNESS_EN
            exp_q.push_back((j % 3 == 2) ? 32'd1 : 32'd2);
`else
            exp_q.push_back(32'd2);
`endif
        end
        if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        k = 0;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (if_ready || dm_ready) begin
                got_who = {30'd0, dm_ready, if_ready};
                chk($sformatf("held.cycle%0d", k), 32'(c), 32'(1 + 3 * k));
                if (exp_q.size() == 0) begin
                    chk("held.extra_completion", got_who, 0);
                end else begin
                    chk($sformatf("held.who%0d", k), got_who, exp_q.pop_front());
                end
                chk($sformatf("held.rdata%0d", k), if_ready ? if_rdata : dm_rdata, 32'hA5A5A5A5);
                k++;
            end
        end
        chk("held.missing_completions", 32'(exp_q.size()), 0);
        drive_idle();
        tick();

        // Reset during GNT_DM, late ack ignored, reissue completes.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        tick();
        chk("rst.gnt_mem_req", 32'(mem_req), 1);
        chk("rst.gnt_owner", 32'(owner), 2);
        reset = 1'b1;
        tick();
        chk("rst.mem_req", 32'(mem_req), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.owner", 32'(owner), 0);
        chk("rst.dm_ready", 32'(dm_ready), 0);
        reset = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick();
        chk("rst.late_ack_ready", 32'(dm_ready), 0);
        chk("rst.late_ack_busy", 32'(busy), 0);
        chk("rst.late_ack_mem_req", 32'(mem_req), 0);
        chk("rst.late_ack_rdata", dm_rdata, 0);
        mem_ack = 1'b0; dm_req = 1'b1;
        tick();
        chk("rst.reissue_mem_req", 32'(mem_req), 1);
        chk("rst.reissue_addr", mem_addr, 32'h80);
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        tick();
        chk("rst.reissue_ready", 32'(dm_ready), 1);
        chk("rst.reissue_rdata", dm_rdata, 32'h33333333);
        drive_idle();
        tick();
        chk("rst.final_busy", 32'(busy), 0);

        // Random run against a transaction-level model with a word-array memory.
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom();
        ph = P_FREE; cur_who = 0; cur_addr = '0; cur_wdata = '0; cur_we = 1'b0; wait_n = 0;
        streak_m = 0; if_act = 1'b0; dm_act = 1'b0; if_a = '0; dm_a = '0; dm_wd = '0; dm_w = 1'b0;
        exp_ifd = '0; exp_dmd = 32'h33333333; n_if_done = 0; n_dm_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd.mem_req", 32'(mem_req), (ph == P_ACC) ? 32'd1 : 32'd0);
            chk("rnd.busy", 32'(busy), (ph != P_FREE) ? 32'd1 : 32'd0);
            chk("rnd.owner", 32'(owner), (ph == P_ACC) ? 32'(cur_who) : 32'd0);
            chk("rnd.if_ready", 32'(if_ready), (ph == P_FIN && cur_who == 1) ? 32'd1 : 32'd0);
            chk("rnd.dm_ready", 32'(dm_ready), (ph == P_FIN && cur_who == 2) ? 32'd1 : 32'd0);
            if (ph == P_ACC) begin
                chk("rnd.mem_addr", mem_addr, cur_addr);
                chk("rnd.mem_we", 32'(mem_we), 32'(cur_we));
                if (cur_who == 2) chk("rnd.mem_wdata", mem_wdata, cur_wdata);
            end
            chk("rnd.if_rdata", if_rdata, exp_ifd);
            chk("rnd.dm_rdata", dm_rdata, exp_dmd);

            if (ph == P_FIN) begin
                if (cur_who == 1) begin if_act = 1'b0; n_if_done++; end
                else begin dm_act = 1'b0; n_dm_done++; end
            end
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1;
                if_a   = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dm_act && $urandom_range(0, 2) == 0) begin
                dm_act = 1'b1;
                dm_a   = 32'($urandom_range(0, 15)) << 2;
                dm_w   = 1'($urandom_range(0, 1));
                dm_wd  = $urandom();
            end
            if_req = if_act; if_addr = if_a;
            dm_req = dm_act; dm_we = dm_w; dm_addr = dm_a; dm_wdata = dm_wd;
            mem_rdata = $urandom();
            if (ph == P_ACC) begin
                mem_ack = (wait_n >= 5) || ($urandom_range(0, 2) == 0);
                if (mem_ack && !cur_we) mem_rdata = mem_model[cur_addr[5:2]];
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end

            case (ph)
                P_FREE: begin
                    if (!if_act) streak_m = 0;
                    force_if = 1'b0;
`ifdef ARB_FAIRNESS_EN
                    force_if = if_act && dm_act && (streak_m == MAX_STREAK);
`endif
                    if (dm_act && !force_if) begin
                        ph = P_ACC; cur_who = 2; cur_addr = dm_a; cur_we = dm_w; cur_wdata = dm_wd; wait_n = 0;
                        if (if_act) streak_m++;
                    end else if (if_act) begin
                        ph = P_ACC; cur_who = 1; cur_addr = if_a; cur_we = 1'b0; cur_wdata = '0; wait_n = 0;
                        streak_m = 0;
                    end
                end
                P_ACC: begin
                    if (mem_ack) begin
                        if (cur_who == 1) exp_ifd = mem_rdata;
                        else if (!cur_we) exp_dmd = mem_rdata;
                        else mem_model[cur_addr[5:2]] = cur_wdata;
                        ph = P_FIN;
                    end else begin
                        wait_n++;
                    end
                end
                default: ph = P_FREE;
            endcase
            tick();
        end
        chk("rnd.fetches_completed", (n_if_done > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("rnd.data_completed", (n_dm_done > 0) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
